intr_ctrl: RTL and testbench
============================

INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter N_SRC, default 4, number of interrupt sources (2..16).
REQ-002 Parameter VEC_W, default $clog2(N_SRC), vector width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 irq_src  input  N_SRC  asynchronous interrupt source lines, active-high.
REQ-006 cfg_we  input  1  configuration write strobe, one cycle per write.
REQ-007 cfg_addr  input  2  register select: 0 MASK, 1 MODE, 2 PEND, 3 reserved.
REQ-008 cfg_wdata  input  N_SRC  write data.
REQ-009 cfg_rdata  output  N_SRC  combinational read of the addressed register; 0 for addr 3.
REQ-010 interrupt  output  1  request to CPU, registered, drives the CPU interrupt port.
REQ-011 intr_vec  output  VEC_W  index of the source being requested/serviced, registered.
REQ-012 intr_ack  input  1  CPU accepts request, one-cycle pulse.
REQ-013 intr_done  input  1  CPU finished handler (RTI), one-cycle pulse.

Function
REQ-014 Each irq_src bit SHALL pass a 2-flop synchronizer; a third flop holds the previous synchronized value.
REQ-015 MASK bit=1 enables the source; MODE bit=1 edge-triggered, 0 level-triggered.
REQ-016 Edge mode: PEND bit set on synchronized 0->1 transition; held until cleared.
REQ-017 Level mode: PEND bit follows the synchronized level each cycle; W1C and ack have no effect on it.
REQ-018 Write to MASK/MODE replaces the register; write to PEND is write-1-to-clear (edge-mode bits only).
REQ-019 Set and clear of the same PEND bit in the same cycle: set wins.
REQ-020 PEND bits latch regardless of MASK; MASK gates only arbitration.
REQ-021 Arbitration: fixed priority, lowest index highest, over PEND & MASK.
REQ-022 FSM states IDLE, REQ, SERVICE.
REQ-023 IDLE: if (PEND & MASK) != 0, latch winning index into intr_vec, set interrupt=1, go REQ; else stay.
REQ-024 REQ: interrupt held 1, intr_vec frozen; MASK/PEND changes do not withdraw the request; on intr_ack clear PEND[intr_vec] (edge mode), interrupt=0, go SERVICE.
REQ-025 SERVICE: interrupt=0, intr_vec held; on intr_done go IDLE; no nesting.
REQ-026 intr_ack outside REQ and intr_done outside SERVICE SHALL be ignored.
REQ-027 Latency: source first sampled high at edge k -> PEND set at edge k+2 -> interrupt high after edge k+3 (IDLE, unmasked).
REQ-028 Back-to-back: from intr_done at edge d, next pending request raises interrupt after edge d+1.
REQ-029 Edge events arriving while the same bit is pending SHALL merge (no counting).

Reset
REQ-030 On reset: MASK=0, MODE=all 1 (edge), PEND=0, synchronizer flops=0, state IDLE, interrupt=0, intr_vec=0.
REQ-031 Reset asserted mid-REQ or mid-SERVICE SHALL abort immediately; no request reissued after release unless a new event occurs.
REQ-032 First edge detection after reset release SHALL treat a source already high as a 0->1 transition.

Verification
REQ-033 MASK=0xF, pulse irq_src[2] 3 cycles -> interrupt=1 at k+3, intr_vec=2; ack -> PEND=0x0, interrupt=0; done -> IDLE.
REQ-034 irq_src[1] and [3] rise same cycle -> intr_vec=1 first; after ack+done, intr_vec=3 one cycle later.
REQ-035 MASK=0x0, pulse irq_src[0] -> PEND=0x1, interrupt stays 0; write MASK=0x1 -> interrupt=1, intr_vec=0.
REQ-036 MODE=0x0, hold irq_src[0] high through ack+done -> interrupt reasserts, intr_vec=0; drop source -> PEND=0, no further request.
REQ-037 W1C PEND=0x4 same cycle as irq_src[2] edge -> PEND[2] stays 1.
REQ-038 reset pulse while in REQ -> interrupt=0, intr_vec=0, MASK=0 immediately; ack afterwards ignored.

Source files
------------

// File: rtl/intr_ctrl.sv
// Interrupt controller: synchronizes N_SRC async sources, latches them into PEND
// (edge or level per source), and hands the highest-priority unmasked source to
// the CPU through a REQ/SERVICE handshake with no nesting.
module intr_ctrl #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned VEC_W = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [N_SRC-1:0] cfg_wdata,
    output logic [N_SRC-1:0] cfg_rdata,
    output logic             interrupt,
    output logic [VEC_W-1:0] intr_vec,
    input  logic             intr_ack,
    input  logic             intr_done
);

    typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

    localparam logic [1:0] AddrMask = 2'd0;
    localparam logic [1:0] AddrMode = 2'd1;
    localparam logic [1:0] AddrPend = 2'd2;

    logic [N_SRC-1:0] sync1_q, sync1_d;
    logic [N_SRC-1:0] sync2_q, sync2_d;
    logic [N_SRC-1:0] prev_q, prev_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] mode_q, mode_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    state_e           state_q, state_d;
    logic             interrupt_q, interrupt_d;
    logic [VEC_W-1:0] vec_q, vec_d;

    logic [N_SRC-1:0] active;
    logic [VEC_W-1:0] win_idx;
    logic             ack_hit;
    logic [N_SRC-1:0] ack_clr;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;

    // Synchronizer chain plus the previous-value flop used for edge detection.
    always_comb begin
        sync1_d = irq_src;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Fixed priority over enabled pending sources; lowest index wins.
    always_comb begin
        active  = pend_q & mask_q;
        win_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                win_idx = VEC_W'(i);
            end
        end
    end

    // Configuration writes and PEND next-state; a new edge beats a same-cycle clear.
    always_comb begin
        mask_d  = mask_q;
        mode_d  = mode_q;
        ack_hit = (state_q == StReq) && intr_ack;
        ack_clr = ack_hit ? ({{(N_SRC - 1){1'b0}}, 1'b1} << vec_q) : '0;
        w1c     = (cfg_we && (cfg_addr == AddrPend)) ? cfg_wdata : '0;
        rise    = sync2_q & ~prev_q;
        clr     = w1c | ack_clr;
        if (cfg_we && (cfg_addr == AddrMask)) begin
            mask_d = cfg_wdata;
        end
        if (cfg_we && (cfg_addr == AddrMode)) begin
            mode_d = cfg_wdata;
        end
        // Level-mode bits simply mirror the synchronized line.
        pend_d = (mode_q & (rise | (pend_q & ~clr))) | (~mode_q & sync2_q);
    end

    // Request handshake: IDLE picks a winner, REQ waits for ack, SERVICE waits for done.
    always_comb begin
        state_d     = state_q;
        interrupt_d = interrupt_q;
        vec_d       = vec_q;
        unique case (state_q)
            StIdle: begin
                if (active != '0) begin
                    vec_d       = win_idx;
                    interrupt_d = 1'b1;
                    state_d     = StReq;
                end
            end
            StReq: begin
                if (intr_ack) begin
                    interrupt_d = 1'b0;
                    state_d     = StService;
                end
            end
            StService: begin
                if (intr_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d     = StIdle;
                interrupt_d = 1'b0;
            end
        endcase
    end

    // Combinational register readback.
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            AddrMask: cfg_rdata = mask_q;
            AddrMode: cfg_rdata = mode_q;
            AddrPend: cfg_rdata = pend_q;
            default:  cfg_rdata = '0;
        endcase
    end

    assign interrupt = interrupt_q;
    assign intr_vec  = vec_q;

    // State registers; reset defaults every source to edge mode, all masked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            mask_q      <= '0;
            mode_q      <= '1;
            pend_q      <= '0;
            state_q     <= StIdle;
            interrupt_q <= 1'b0;
            vec_q       <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            mask_q      <= mask_d;
            mode_q      <= mode_d;
            pend_q      <= pend_d;
            state_q     <= state_d;
            interrupt_q <= interrupt_d;
            vec_q       <= vec_d;
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural reference model.
module tb_intr_ctrl;

    localparam int N  = 4;
    localparam int VW = 2;

    logic          clk;
    logic          reset;
    logic [N-1:0]  irq_src;
    logic          cfg_we;
    logic [1:0]    cfg_addr;
    logic [N-1:0]  cfg_wdata;
    logic [N-1:0]  cfg_rdata;
    logic          interrupt;
    logic [VW-1:0] intr_vec;
    logic          intr_ack;
    logic          intr_done;

    int errs   = 0;
    int checks = 0;

    intr_ctrl #(.N_SRC(N), .VEC_W(VW)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_src   (irq_src),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .interrupt (interrupt),
        .intr_vec  (intr_vec),
        .intr_ack  (intr_ack),
        .intr_done (intr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Samples of irq_src taken at the last three edges (newest first in naming).
    logic [N-1:0]  h_new, h_mid, h_old;
    logic [N-1:0]  m_mask, m_mode, m_pend;
    int            m_phase;  // 0 waiting, 1 requesting, 2 servicing
    logic          m_int;
    logic [VW-1:0] m_vec;

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Line seen by the pend logic is the sample two edges old; prior is three edges old.
    function automatic logic [N-1:0] pend_rule(input logic [N-1:0] pend, input logic [N-1:0] mode,
                                               input logic [N-1:0] seen, input logic [N-1:0] prior,
                                               input logic [N-1:0] w1c, input logic [N-1:0] ackm);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            if (mode[i]) r[i] = (seen[i] && !prior[i]) || (pend[i] && !(w1c[i] || ackm[i]));
            else         r[i] = seen[i];
        end
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            h_new <= '0; h_mid <= '0; h_old <= '0;
            m_mask <= '0; m_mode <= '1; m_pend <= '0;
            m_phase <= 0; m_int <= 1'b0; m_vec <= '0;
        end else begin
            m_pend <= pend_rule(m_pend, m_mode, h_mid, h_old,
                                (cfg_we && cfg_addr == 2'd2) ? cfg_wdata : 4'b0,
                                (m_phase == 1 && intr_ack) ? (4'b1 << m_vec) : 4'b0);
            case (m_phase)
                0: if ((m_pend & m_mask) != 0) begin
                    m_phase <= 1; m_int <= 1'b1; m_vec <= VW'(lowest(m_pend & m_mask));
                end
                1: if (intr_ack) begin
                    m_phase <= 2; m_int <= 1'b0;
                end
                2: if (intr_done) m_phase <= 0;
                default: m_phase <= 0;
            endcase
            if (cfg_we && cfg_addr == 2'd0) m_mask <= cfg_wdata;
            if (cfg_we && cfg_addr == 2'd1) m_mode <= cfg_wdata;
            h_old <= h_mid; h_mid <= h_new; h_new <= irq_src;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        irq_src = '0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
        intr_ack = 1'b0; intr_done = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [N-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        cyc(1);
        cfg_we = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [N-1:0] d);
        cfg_addr = a;
        #1 d = cfg_rdata;
    endtask

    task automatic pulse_ack();
        intr_ack = 1'b1; cyc(1); intr_ack = 1'b0;
    endtask

    task automatic pulse_done();
        intr_done = 1'b1; cyc(1); intr_done = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [N-1:0] r;
        do_reset();
        #1;
        checks++; if (interrupt !== 1'b0) begin errs++; $display("FAIL rst_int: got %b want 0", interrupt); end
        checks++; if (intr_vec !== 2'd0) begin errs++; $display("FAIL rst_vec: got %0d want 0", intr_vec); end
        read_reg(2'd0, r);
        checks++; if (r !== 4'h0) begin errs++; $display("FAIL rst_mask: got %h want 0", r); end
        read_reg(2'd1, r);
        checks++; if (r !== 4'hF) begin errs++; $display("FAIL rst_mode: got %h want f", r); end
        read_reg(2'd2, r);
        checks++; if (r !== 4'h0) begin errs++; $display("FAIL rst_pend: got %h want 0", r); end
        cfg_write(2'd3, 4'hF);
        read_reg(2'd3, r);
        checks++; if (r !== 4'h0) begin errs++; $display("FAIL rsvd_read: got %h want 0", r); end
        read_reg(2'd0, r);
        checks++; if (r !== 4'h0) begin errs++; $display("FAIL rsvd_nowrite: mask got %h want 0", r); end
    endtask

    task automatic test_edge_latency();
        logic [N-1:0] r;
        do_reset();
        cfg_write(2'd0, 4'hF);
        irq_src = 4'b0100;
        cyc(3);
        irq_src = 4'b0000;
        read_reg(2'd2, r);
        checks++; if (r !== 4'h4) begin errs++; $display("FAIL lat_pend_k2: got %h want 4", r); end
        checks++; if (interrupt !== 1'b0) begin errs++; $display("FAIL lat_int_k2: got %b want 0", interrupt); end
        cyc(1);
        checks++; if (interrupt !== 1'b1) begin errs++; $display("FAIL lat_int_k3: got %b want 1", interrupt); end
        checks++; if (intr_vec !== 2'd2) begin errs++; $display("FAIL lat_vec: got %0d want 2", intr_vec); end
        pulse_ack();
        read_reg(2'd2, r);
        checks++; if (r !== 4'h0) begin errs++; $display("FAIL ack_clr_pend: got %h want 0", r); end
        checks++; if (interrupt !== 1'b0) begin errs++; $display("FAIL ack_int: got %b want 0", interrupt); end
        checks++; if (intr_vec !== 2'd2) begin errs++; $display("FAIL svc_vec_hold: got %0d want 2", intr_vec); end
        pulse_done();
        cyc(2);
        checks++; if (interrupt !== 1'b0) begin errs++; $display("FAIL done_idle: got %b want 0", interrupt); end
        pulse_ack();
        cyc(2);
        checks++; if (interrupt !== 1'b0) begin errs++; $display("FAIL stray_ack: got %b want 0", interrupt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cfg_write(2'd0, 4'hF);
        irq_src = 4'b1010;
        cyc(4);
        checks++; if (interrupt !== 1'b1) begin errs++; $display("FAIL b2b_int1: got %b want 1", interrupt); end
        checks++; if (intr_vec !== 2'd1) begin errs++; $display("FAIL b2b_vec1: got %0d want 1", intr_vec); end
        pulse_ack();
        pulse_done();
        checks++; if (interrupt !== 1'b0) begin errs++; $display("FAIL b2b_gap: got %b want 0", interrupt); end
        cyc(1);
        checks++; if (interrupt !== 1'b1) begin errs++; $display("FAIL b2b_int2: got %b want 1", interrupt); end
        checks++; if (intr_vec !== 2'd3) begin errs++; $display("FAIL b2b_vec2: got %0d want 3", intr_vec); end
        pulse_ack();
        pulse_done();
        irq_src = 4'b0000;
    endtask

    task automatic test_masked_pend();
        logic [N-1:0] r;
        do_reset();
        irq_src = 4'b0001;
        cyc(2);
        irq_src = 4'b0000;
        cyc(3);
        read_reg(2'd2, r);
        checks++; if (r !== 4'h1) begin errs++; $display("FAIL mask_pend: got %h want 1", r); end
        checks++; if (interrupt !== 1'b0) begin errs++; $display("FAIL mask_int0: got %b want 0", interrupt); end
        cfg_write(2'd0, 4'h1);
        cyc(1);
        checks++; if (interrupt !== 1'b1) begin errs++; $display("FAIL unmask_int: got %b want 1", interrupt); end
        checks++; if (intr_vec !== 2'd0) begin errs++; $display("FAIL unmask_vec: got %0d want 0", intr_vec); end
    endtask

    task automatic test_level();
        logic [N-1:0] r;
        do_reset();
        cfg_write(2'd1, 4'h0);
        cfg_write(2'd0, 4'h1);
        irq_src = 4'b0001;
        cyc(4);
        checks++; if (interrupt !== 1'b1) begin errs++; $display("FAIL lvl_int1: got %b want 1", interrupt); end
        pulse_ack();
        read_reg(2'd2, r);
        checks++; if (r !== 4'h1) begin errs++; $display("FAIL lvl_ack_noclr: got %h want 1", r); end
        pulse_done();
        cyc(1);
        checks++; if (interrupt !== 1'b1) begin errs++; $display("FAIL lvl_reassert: got %b want 1", interrupt); end
        checks++; if (intr_vec !== 2'd0) begin errs++; $display("FAIL lvl_vec: got %0d want 0", intr_vec); end
        irq_src = 4'b0000;
        pulse_ack();
        cyc(4);
        read_reg(2'd2, r);
        checks++; if (r !== 4'h0) begin errs++; $display("FAIL lvl_drop: got %h want 0", r); end
        pulse_done();
        cyc(4);
        checks++; if (interrupt !== 1'b0) begin errs++; $display("FAIL lvl_noreq: got %b want 0", interrupt); end
    endtask

    task automatic test_w1c_race();
        logic [N-1:0] r;
        do_reset();
        irq_src = 4'b0100;
        cyc(2);
        cfg_write(2'd2, 4'h4);
        read_reg(2'd2, r);
        checks++; if (r !== 4'h4) begin errs++; $display("FAIL w1c_set_wins: got %h want 4", r); end
        cfg_write(2'd2, 4'h4);
        read_reg(2'd2, r);
        checks++; if (r !== 4'h0) begin errs++; $display("FAIL w1c_clear: got %h want 0", r); end
        irq_src = 4'b0000;
    endtask

    task automatic test_reset_mid_req();
        logic [N-1:0] r;
        do_reset();
        cfg_write(2'd0, 4'hF);
        irq_src = 4'b0010;
        cyc(2);
        irq_src = 4'b0000;
        cyc(2);
        checks++; if (interrupt !== 1'b1 || intr_vec !== 2'd1) begin
            errs++; $display("FAIL pre_rst_req: got int=%b vec=%0d want int=1 vec=1", interrupt, intr_vec);
        end
        reset = 1'b1;
        #1;
        checks++; if (interrupt !== 1'b0) begin errs++; $display("FAIL async_rst_int: got %b want 0", interrupt); end
        checks++; if (intr_vec !== 2'd0) begin errs++; $display("FAIL async_rst_vec: got %0d want 0", intr_vec); end
        read_reg(2'd0, r);
        checks++; if (r !== 4'h0) begin errs++; $display("FAIL async_rst_mask: got %h want 0", r); end
        reset = 1'b0;
        pulse_ack();
        cyc(3);
        checks++; if (interrupt !== 1'b0) begin errs++; $display("FAIL post_rst_ack: got %b want 0", interrupt); end
    endtask

    task automatic test_random();
        logic [N-1:0] want_rd;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1; #1 reset = 1'b0;
            end
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) irq_src[b] = ~irq_src[b];
            end
            cfg_we    = ($urandom_range(0, 9) == 0);
            cfg_addr  = 2'($urandom_range(0, 3));
            cfg_wdata = 4'($urandom);
            intr_ack  = ($urandom_range(0, 2) == 0);
            intr_done = ($urandom_range(0, 3) == 0);
            #1;
            case (cfg_addr)
                2'd0:    want_rd = m_mask;
                2'd1:    want_rd = m_mode;
                2'd2:    want_rd = m_pend;
                default: want_rd = '0;
            endcase
            checks++; if (interrupt !== m_int) begin
                errs++; $display("FAIL rnd_int c=%0d: got %b want %b", c, interrupt, m_int);
            end
            checks++; if (intr_vec !== m_vec) begin
                errs++; $display("FAIL rnd_vec c=%0d: got %0d want %0d", c, intr_vec, m_vec);
            end
            checks++; if (cfg_rdata !== want_rd) begin
                errs++; $display("FAIL rnd_rdata c=%0d a=%0d: got %h want %h", c, cfg_addr, cfg_rdata, want_rd);
            end
            cyc(1);
        end
        cfg_we = 1'b0; intr_ack = 1'b0; intr_done = 1'b0; irq_src = '0;
    endtask

    initial begin
        reset = 1'b0; irq_src = '0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
        intr_ack = 1'b0; intr_done = 1'b0;
        test_reset();
        test_edge_latency();
        test_back_to_back();
        test_masked_pend();
        test_level();
        test_w1c_race();
        test_reset_mid_req();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
